// File: rtl/pistorm_txn_master.sv
// Pi-side bus master for the PiStorm CPLD bridge. It turns one 68k request into the
// bridge's DATA / ADDR_LO / ADDR_HI / poll / DATA register sequence and also issues STATUS writes.
module pistorm_txn_master #(
    parameter int SETUP_CYC   = 2,
    parameter int STROBE_CYC  = 4,
    parameter int HOLD_CYC    = 2,
    parameter int POLL_DELAY  = 8,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic        PI_CLK,
    input  logic        RESET,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_rw,
    input  logic        req_byte,
    input  logic [23:0] req_addr,
    input  logic [15:0] req_wdata,
    input  logic        ctl_valid,
    output logic        ctl_ready,
    input  logic [15:0] ctl_data,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_timeout,
    output logic        busy,
    output logic [1:0]  PI_A,
    output logic [15:0] PI_D_OUT,
    output logic        PI_D_OE,
    input  logic [15:0] PI_D_IN,
    output logic        PI_WR,
    output logic        PI_RD,
    input  logic        PI_TXN_IN_PROGRESS
);
    localparam int PH_MAX = (SETUP_CYC > STROBE_CYC)
                          ? ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC)
                          : ((STROBE_CYC > HOLD_CYC) ? STROBE_CYC : HOLD_CYC);
    localparam int PH_W = $clog2(PH_MAX + 1);
    localparam int PC_MAX = (TIMEOUT_CYC > POLL_DELAY) ? TIMEOUT_CYC : POLL_DELAY;
    localparam int PC_W = $clog2(PC_MAX + 1);

    localparam logic [PH_W-1:0] SETUP_LAST   = PH_W'(SETUP_CYC - 1);
    localparam logic [PH_W-1:0] STROBE_LAST  = PH_W'(STROBE_CYC - 1);
    localparam logic [PH_W-1:0] HOLD_LAST    = PH_W'(HOLD_CYC - 1);
    localparam logic [PC_W-1:0] DELAY_END    = PC_W'(POLL_DELAY);
    localparam logic [PC_W-1:0] TIMEOUT_LAST = PC_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        IDLE, WR_DATA, WR_ALO, WR_AHI, POLL, RD_DATA, RESP, WR_STAT
    } state_t;
    typedef enum logic [1:0] {PH_SETUP, PH_STROBE, PH_HOLD} phase_t;

    state_t          state, state_nx;
    phase_t          phase, phase_nx;
    logic [PH_W-1:0] ph_cnt, ph_cnt_nx;
    logic [PC_W-1:0] poll_cnt, poll_cnt_nx;
    logic            txn_meta, txn_s;
    logic            is_bus, prim_done, rd_capture, poll_expire;
    logic            req_accept, ctl_accept;

    logic            rw_q, byte_q;
    logic [23:0]     addr_q;
    logic [15:0]     wdata_q, ctl_q, rdata_q;
    logic            timeout_q;

    // Byte reads return the addressed lane in [7:0]; even addresses sit on D[15:8].
    function automatic logic [15:0] lane_select(input logic byte_acc, input logic a0,
                                                input logic [15:0] d);
        if (!byte_acc)
            return d;
        return a0 ? {8'h00, d[7:0]} : {8'h00, d[15:8]};
    endfunction

    // State, phase and counter registers; TXN_IN_PROGRESS crosses through two flops.
    always_ff @(posedge PI_CLK) begin
        if (RESET) begin
            state    <= IDLE;
            phase    <= PH_SETUP;
            ph_cnt   <= '0;
            poll_cnt <= '0;
            txn_meta <= 1'b0;
            txn_s    <= 1'b0;
        end else begin
            state    <= state_nx;
            phase    <= phase_nx;
            ph_cnt   <= ph_cnt_nx;
            poll_cnt <= poll_cnt_nx;
            txn_meta <= PI_TXN_IN_PROGRESS;
            txn_s    <= txn_meta;
        end
    end

    always_comb begin
        state_nx    = state;
        phase_nx    = PH_SETUP;
        ph_cnt_nx   = '0;
        poll_cnt_nx = '0;
        prim_done   = 1'b0;
        rd_capture  = 1'b0;
        poll_expire = 1'b0;
        req_ready   = 1'b0;
        ctl_ready   = 1'b0;
        rsp_valid   = 1'b0;
        PI_A        = 2'd0;
        PI_D_OUT    = 16'h0000;
        PI_D_OE     = 1'b0;
        PI_WR       = 1'b0;
        PI_RD       = 1'b0;
        is_bus      = (state == WR_DATA) || (state == WR_ALO) || (state == WR_AHI) ||
                      (state == RD_DATA) || (state == WR_STAT);

        // Shared setup/strobe/hold primitive; prim_done marks its final cycle.
        if (is_bus) begin
            phase_nx  = phase;
            ph_cnt_nx = ph_cnt + 1'b1;
            PI_D_OE   = (state != RD_DATA);
            case (phase)
                PH_SETUP: begin
                    if (ph_cnt == SETUP_LAST) begin
                        phase_nx  = PH_STROBE;
                        ph_cnt_nx = '0;
                    end
                end
                PH_STROBE: begin
                    PI_WR = (state != RD_DATA);
                    PI_RD = (state == RD_DATA);
                    if (ph_cnt == STROBE_LAST) begin
                        phase_nx   = PH_HOLD;
                        ph_cnt_nx  = '0;
                        rd_capture = (state == RD_DATA);
                    end
                end
                PH_HOLD: begin
                    if (ph_cnt == HOLD_LAST) begin
                        phase_nx  = PH_SETUP;
                        ph_cnt_nx = '0;
                        prim_done = 1'b1;
                    end
                end
                default: begin
                    phase_nx  = PH_SETUP;
                    ph_cnt_nx = '0;
                end
            endcase
        end

        unique case (state)
            IDLE: begin
                ctl_ready = !RESET;
                req_ready = !RESET && !ctl_valid;
                if (ctl_valid && ctl_ready)
                    state_nx = WR_STAT;
                else if (req_valid && req_ready)
                    state_nx = req_rw ? WR_ALO : WR_DATA;
            end
            WR_DATA: begin
                PI_A     = 2'd0;
                PI_D_OUT = byte_q ? {wdata_q[7:0], wdata_q[7:0]} : wdata_q;
                if (prim_done) state_nx = WR_ALO;
            end
            WR_ALO: begin
                PI_A     = 2'd1;
                PI_D_OUT = addr_q[15:0];
                if (prim_done) state_nx = WR_AHI;
            end
            WR_AHI: begin
                PI_A     = 2'd2;
                PI_D_OUT = {6'b000000, rw_q, byte_q, addr_q[23:16]};
                if (prim_done) state_nx = POLL;
            end
            POLL: begin
                // The bridge's busy flag is ignored for the first POLL_DELAY cycles.
                if (poll_cnt >= DELAY_END && !txn_s) begin
                    state_nx = rw_q ? RD_DATA : RESP;
                end else if (poll_cnt == TIMEOUT_LAST) begin
                    state_nx    = RESP;
                    poll_expire = 1'b1;
                end else begin
                    poll_cnt_nx = poll_cnt + 1'b1;
                end
            end
            RD_DATA: begin
                PI_A = 2'd0;
                if (prim_done) state_nx = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                state_nx  = IDLE;
            end
            WR_STAT: begin
                PI_A     = 2'd3;
                PI_D_OUT = ctl_q;
                if (prim_done) state_nx = IDLE;
            end
        endcase
    end

    assign req_accept  = req_valid && req_ready;
    assign ctl_accept  = ctl_valid && ctl_ready;
    assign busy        = (state != IDLE);
    assign rsp_rdata   = rdata_q;
    assign rsp_timeout = timeout_q;

    // Response registers are cleared at request acceptance so writes and timeouts return 0.
    always_ff @(posedge PI_CLK) begin
        if (RESET) begin
            rdata_q   <= 16'h0000;
            timeout_q <= 1'b0;
        end else begin
            if (req_accept) begin
                rdata_q   <= 16'h0000;
                timeout_q <= 1'b0;
            end
            if (poll_expire) timeout_q <= 1'b1;
            if (rd_capture) rdata_q <= lane_select(byte_q, addr_q[0], PI_D_IN);
        end
    end

    always_ff @(posedge PI_CLK) begin
        if (req_accept) begin
            rw_q    <= req_rw;
            byte_q  <= req_byte;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
        end
        if (ctl_accept) ctl_q <= ctl_data;
    end
endmodule

// File: tb/tb_pistorm_txn_master.sv
// Self-checking bench for pistorm_txn_master: a bridge model on the Pi bus plus a
// transaction-level reference model that predicts the bus writes, timing and response.
module tb_pistorm_txn_master;
    localparam int S = 2, ST = 4, H = 2, PD = 8, TO = 300;
    localparam int PRIM = S + ST + H;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, req_rw = 1'b0, req_byte = 1'b0;
    logic [23:0] req_addr = '0;
    logic [15:0] req_wdata = '0, ctl_data = '0;
    logic        ctl_valid = 1'b0;
    logic        req_ready, ctl_ready, rsp_valid, rsp_timeout, busy;
    logic [15:0] rsp_rdata, pi_d_out;
    logic [1:0]  pi_a;
    logic        pi_d_oe, pi_wr, pi_rd;
    logic [15:0] bridge_d = '0;
    logic        txn = 1'b0;

    int checks = 0;
    int failures = 0;

    // Bridge model / bus monitor state (written only by the monitor process).
    int          cyc = 0;
    logic [18:0] wlog[$];
    int          wlog_t[$];
    int          rd_rises = 0, rd_t = 0, bad_width = 0, both_hi = 0, rsp_cnt = 0;
    int          wr_w = 0, rd_w = 0, txn_cnt = 0;
    logic        wr_prev = 1'b0, rd_prev = 1'b0, hold_armed = 1'b0;
    // Bridge configuration (written only by the stimulus process).
    int          txn_dly = 20;
    bit          txn_hold = 1'b0;

    always #5 clk = ~clk;

    pistorm_txn_master #(
        .SETUP_CYC(S), .STROBE_CYC(ST), .HOLD_CYC(H), .POLL_DELAY(PD), .TIMEOUT_CYC(TO)
    ) dut (
        .PI_CLK(clk), .RESET(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw), .req_byte(req_byte),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .ctl_valid(ctl_valid), .ctl_ready(ctl_ready), .ctl_data(ctl_data),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout), .busy(busy),
        .PI_A(pi_a), .PI_D_OUT(pi_d_out), .PI_D_OE(pi_d_oe), .PI_D_IN(bridge_d),
        .PI_WR(pi_wr), .PI_RD(pi_rd), .PI_TXN_IN_PROGRESS(txn)
    );

    // Bridge: raises TXN when ADDR_LO is written and drops it txn_dly cycles later.
    always @(negedge clk) begin
        cyc++;
        if (!txn_hold) hold_armed = 1'b0;
        if (txn_cnt > 0) txn_cnt--;
        if (pi_wr && !wr_prev) begin
            wlog.push_back({pi_d_oe, pi_a, pi_d_out});
            wlog_t.push_back(cyc);
            if (pi_a == 2'd1) begin
                if (txn_hold) hold_armed = 1'b1;
                else txn_cnt = txn_dly;
            end
        end
        if (pi_rd && !rd_prev) begin
            rd_rises++;
            rd_t = cyc;
        end
        if (pi_wr) wr_w++;
        else begin
            if (wr_prev && wr_w != ST) bad_width++;
            wr_w = 0;
        end
        if (pi_rd) rd_w++;
        else begin
            if (rd_prev && rd_w != ST) bad_width++;
            rd_w = 0;
        end
        if (pi_wr && pi_rd) both_hi++;
        if (rsp_valid) rsp_cnt++;
        wr_prev = pi_wr;
        rd_prev = pi_rd;
        txn = hold_armed || (txn_cnt > 0);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic start_req(input bit rw, input bit bt, input logic [23:0] addr,
                             input logic [15:0] wd, output int k, output bit ok);
        @(negedge clk); #1;
        req_rw = rw; req_byte = bt; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
        ok = 1'b0; k = 0;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (req_ready) begin
                ok = 1'b1; k = cyc;
                break;
            end
            @(negedge clk); #1;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output bit ok, output int t, output logic [15:0] rd, output logic to);
        ok = 1'b0; t = 0; rd = '0; to = 1'b0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge clk); #1;
            if (rsp_valid) begin
                ok = 1'b1; t = cyc; rd = rsp_rdata; to = rsp_timeout;
            end
        end
    endtask

    // Reference model: bus writes, their timing, POLL exit and the response, from the rules.
    task automatic model_check(input bit rw, input bit bt, input logic [23:0] addr,
                               input logic [15:0] wd, input logic [15:0] bd, input int dly,
                               input bit hold, input int k, input int wb, input int rdb,
                               input int t, input logic [15:0] rd, input logic to);
        logic [18:0] ew[$];
        int t_alo, p, c, et, erds;
        logic [15:0] erd;
        logic eto;
        ew = {};
        if (!rw) ew.push_back({1'b1, 2'd0, bt ? {wd[7:0], wd[7:0]} : wd});
        ew.push_back({1'b1, 2'd1, addr[15:0]});
        ew.push_back({1'b1, 2'd2, 6'b000000, rw, bt, addr[23:16]});
        check("write_count", 32'(wlog.size() - wb), 32'(ew.size()));
        for (int i = 0; i < ew.size() && wb + i < wlog.size(); i++) begin
            check("bus_write", 32'(wlog[wb + i]), 32'(ew[i]));
            check("write_time", 32'(wlog_t[wb + i]), 32'(k + 1 + S + i * PRIM));
        end
        t_alo = k + 1 + S + (rw ? 0 : PRIM);
        p = t_alo + PRIM + ST + H;
        c = p + PD;
        if (t_alo + dly + 2 > c) c = t_alo + dly + 2;
        if (hold || c > p + TO - 1) begin
            et = p + TO; erd = '0; eto = 1'b1; erds = 0;
        end else begin
            eto = 1'b0;
            erds = rw ? 1 : 0;
            et = rw ? c + 1 + PRIM : c + 1;
            if (!rw) erd = '0;
            else if (!bt) erd = bd;
            else erd = addr[0] ? {8'h00, bd[7:0]} : {8'h00, bd[15:8]};
        end
        check("rsp_time", 32'(t), 32'(et));
        check("rsp_rdata", 32'(rd), 32'(erd));
        check("rsp_timeout", 32'(to), 32'(eto));
        check("rd_strobes", 32'(rd_rises - rdb), 32'(erds));
        if (erds == 1) check("rd_strobe_time", 32'(rd_t), 32'(c + 1 + S));
    endtask

    task automatic run_txn(input bit rw, input bit bt, input logic [23:0] addr,
                           input logic [15:0] wd, input logic [15:0] bd, input int dly,
                           input bit hold, output logic [15:0] rdata,
                           output logic [15:0] d0, output logic [15:0] dlast);
        int wb, rb, rdb, bwb, bhb, k, t;
        bit ok, ok2;
        logic to;
        bridge_d = bd; txn_dly = dly; txn_hold = hold;
        wb = wlog.size(); rb = rsp_cnt; rdb = rd_rises; bwb = bad_width; bhb = both_hi;
        start_req(rw, bt, addr, wd, k, ok);
        check("req_accept", 32'(ok), 32'd1);
        wait_rsp(ok2, t, rdata, to);
        check("rsp_seen", 32'(ok2), 32'd1);
        repeat (3) @(negedge clk);
        #1;
        model_check(rw, bt, addr, wd, bd, dly, hold, k, wb, rdb, t, rdata, to);
        check("rsp_pulses", 32'(rsp_cnt - rb), 32'd1);
        check("strobe_width", 32'(bad_width - bwb), 32'd0);
        check("wr_rd_overlap", 32'(both_hi - bhb), 32'd0);
        check("busy_after", 32'(busy), 32'd0);
        d0 = (wlog.size() > wb) ? wlog[wb][15:0] : 16'h0000;
        dlast = (wlog.size() > wb) ? wlog[wlog.size() - 1][15:0] : 16'h0000;
        txn_hold = 1'b0;
    endtask

    typedef struct {
        bit          rw;
        bit          bt;
        logic [23:0] addr;
        logic [15:0] wd;
        logic [15:0] bd;
        int          dly;
        logic [15:0] exp_rdata;
        logic [15:0] exp_d0;
        logic [15:0] exp_a2;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic [15:0] rd, d0, dl;
        int k, kc, t, wb, rb, rdb;
        bit ok, seen;
        logic to;

        vecs[0] = '{1'b0, 1'b0, 24'h123456, 16'hBEEF, 16'h0000, 20, 16'h0000, 16'hBEEF, 16'h0012};
        vecs[1] = '{1'b1, 1'b1, 24'h000001, 16'h0000, 16'hAA55, 20, 16'h0055, 16'h0001, 16'h0300};
        vecs[2] = '{1'b1, 1'b1, 24'h000000, 16'h0000, 16'hAA55, 3,  16'h00AA, 16'h0000, 16'h0300};
        vecs[3] = '{1'b0, 1'b1, 24'h00FF01, 16'h00C3, 16'h0000, 25, 16'h0000, 16'hC3C3, 16'h0100};
        vecs[4] = '{1'b1, 1'b0, 24'hABCDEE, 16'h0000, 16'h1357, 30, 16'h1357, 16'hCDEE, 16'h02AB};

        // Reset state, with a request pending that must not be accepted.
        req_valid = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_ctl_ready", 32'(ctl_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rsp", 32'({rsp_valid, rsp_timeout, rsp_rdata}), 32'd0);
        check("rst_bus", 32'({pi_a, pi_d_out, pi_d_oe, pi_wr, pi_rd}), 32'd0);
        req_valid = 1'b0;
        @(negedge clk); #1;
        rst = 1'b0;
        #1;
        check("idle_req_ready", 32'(req_ready), 32'd1);
        check("idle_ctl_ready", 32'(ctl_ready), 32'd1);

        for (int i = 0; i < 5; i++) begin
            run_txn(vecs[i].rw, vecs[i].bt, vecs[i].addr, vecs[i].wd, vecs[i].bd,
                    vecs[i].dly, 1'b0, rd, d0, dl);
            check("vec_rdata", 32'(rd), 32'(vecs[i].exp_rdata));
            check("vec_first_d", 32'(d0), 32'(vecs[i].exp_d0));
            check("vec_addr_hi", 32'(dl), 32'(vecs[i].exp_a2));
        end

        // Bridge never finishes: timeout response, no DATA read.
        run_txn(1'b1, 1'b0, 24'h000200, 16'h0000, 16'h7777, 0, 1'b1, rd, d0, dl);

        // STATUS write takes priority over a simultaneous request.
        bridge_d = 16'h0000; txn_dly = 5;
        wb = wlog.size(); rb = rsp_cnt; rdb = rd_rises;
        @(negedge clk); #1;
        ctl_data = 16'h5A5A; ctl_valid = 1'b1;
        req_rw = 1'b0; req_byte = 1'b0; req_addr = 24'h000100; req_wdata = 16'h1111;
        req_valid = 1'b1;
        #1;
        check("prio_req_ready", 32'(req_ready), 32'd0);
        check("prio_ctl_ready", 32'(ctl_ready), 32'd1);
        kc = cyc;
        @(posedge clk); #1;
        ctl_valid = 1'b0;
        ok = 1'b0; k = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk); #2;
            if (req_ready) begin
                ok = 1'b1; k = cyc;
                break;
            end
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("req_after_stat", 32'(ok), 32'd1);
        check("stat_turnaround", 32'(k), 32'(kc + 1 + PRIM));
        check("stat_write", (wlog.size() > wb) ? 32'(wlog[wb]) : 32'd0,
              32'({1'b1, 2'd3, 16'h5A5A}));
        wait_rsp(ok, t, rd, to);
        check("rsp_seen_after_stat", 32'(ok), 32'd1);
        repeat (3) @(negedge clk);
        #1;
        model_check(1'b0, 1'b0, 24'h000100, 16'h1111, 16'h0000, 5, 1'b0, k, wb + 1, rdb, t, rd, to);
        check("stat_no_rsp", 32'(rsp_cnt - rb), 32'd1);

        // Reset during the ADDR_HI strobe drops the bus and loses the request.
        txn_dly = 20;
        start_req(1'b0, 1'b0, 24'h00ABCD, 16'h2222, k, ok);
        check("rst_txn_accept", 32'(ok), 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk); #1;
            if (pi_wr && pi_a == 2'd2) begin
                seen = 1'b1;
                break;
            end
        end
        check("ahi_strobe_seen", 32'(seen), 32'd1);
        rb = rsp_cnt;
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_wr", 32'(pi_wr), 32'd0);
        check("midrst_oe", 32'(pi_d_oe), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_rsp", 32'(rsp_valid), 32'd0);
        @(negedge clk); #1;
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("midrst_no_rsp", 32'(rsp_cnt - rb), 32'd0);
        run_txn(1'b1, 1'b0, 24'h00ABCD, 16'h0000, 16'h4242, 12, 1'b0, rd, d0, dl);

        // Randomized transactions against the reference model.
        for (int i = 0; i < 20; i++) begin
            run_txn(1'($urandom), 1'($urandom), 24'($urandom), 16'($urandom), 16'($urandom),
                    int'($urandom_range(40, 1)), 1'b0, rd, d0, dl);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
